// File: rtl/interrupt_fsm.sv
// Interrupt entry sequencer: on a pending request it stalls fetch, injects pushes
// of PC and flags, loads the vector address, then drains the pipeline with NOPs.
module interrupt_fsm #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0010,
  parameter logic [15:0] NOP_INSTR    = 16'h0000,
  parameter logic [15:0] PUSH_INSTR   = 16'h2800,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intr,
  input  logic        busy,
  input  logic        rti,
  input  logic [31:0] pc_current,
  input  logic [4:0]  ccr_current,
  output logic [15:0] out,
  output logic [15:0] push_data,
  output logic        stall,
  output logic        change_pc_int,
  output logic [31:0] pc,
  output logic        in_isr
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, JUMP, DRAIN
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t      state, state_nx;
  logic        pending;
  logic [31:0] saved_pc;
  logic [4:0]  saved_ccr;
  logic [2:0]  drain_cnt;
  logic        enter;

  assign enter = (state == IDLE) && pending && !busy && !in_isr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      in_isr    <= 1'b0;
      saved_pc  <= '0;
      saved_ccr <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;
      // A new request landing on the entry edge stays pending for the next service
      if (intr)
        pending <= 1'b1;
      else if (enter)
        pending <= 1'b0;
      if (enter) begin
        saved_pc  <= pc_current;
        saved_ccr <= ccr_current;
      end
      if (state == JUMP)
        in_isr <= 1'b1;
      else if (rti && in_isr)
        in_isr <= 1'b0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_nx      = state;
    stall         = 1'b1;
    out           = NOP_INSTR;
    push_data     = 16'h0000;
    change_pc_int = 1'b0;
    pc            = 32'h0;
    unique case (state)
      IDLE: begin
        stall = 1'b0;
        if (enter) state_nx = PUSH_HI;
      end
      PUSH_HI: begin
        out       = PUSH_INSTR;
        push_data = saved_pc[31:16];
        state_nx  = PUSH_LO;
      end
      PUSH_LO: begin
        out       = PUSH_INSTR;
        push_data = saved_pc[15:0];
        state_nx  = PUSH_CCR;
      end
      PUSH_CCR: begin
        out       = PUSH_INSTR;
        push_data = {11'b0, saved_ccr};
        state_nx  = JUMP;
      end
      JUMP: begin
        change_pc_int = 1'b1;
        pc            = VECTOR_ADDR;
        state_nx      = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nx = IDLE;
      end
      default: begin
        stall    = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_fsm.sv
// Directed bench for interrupt_fsm: entry sequence, busy hold-off, nesting, reset abort, rti.
module tb_interrupt_fsm;
  logic        clk = 1'b0;
  logic        reset, intr, busy, rti;
  logic [31:0] pc_current;
  logic [4:0]  ccr_current;
  logic [15:0] out, push_data;
  logic        stall, change_pc_int, in_isr;
  logic [31:0] pc;
  int tests = 0;
  int fails = 0;

  interrupt_fsm dut (
    .clk(clk), .reset(reset), .intr(intr), .busy(busy), .rti(rti),
    .pc_current(pc_current), .ccr_current(ccr_current),
    .out(out), .push_data(push_data), .stall(stall),
    .change_pc_int(change_pc_int), .pc(pc), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse intr and run until the sequence has returned to IDLE (in_isr left at 1).
  task automatic run_entry();
    intr = 1'b1; step(); intr = 1'b0;
    step(8);
  endtask

  task automatic clear_isr();
    rti = 1'b1; step(); rti = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; intr = 1'b1; rti = 1'b1; busy = 1'b0;
    pc_current = 32'h0; ccr_current = 5'b0;
    step(2);
    reset = 1'b0; intr = 1'b0; rti = 1'b0;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
    tests++; if (in_isr !== 1'b0) begin fails++; $display("FAIL reset_in_isr got %b exp 0", in_isr); end
    tests++; if (out !== 16'h0000 || push_data !== 16'h0000 || pc !== 32'h0 || change_pc_int !== 1'b0) begin
      fails++; $display("FAIL reset_outs got out=%h push=%h pc=%h cpc=%b exp 0000/0000/0/0", out, push_data, pc, change_pc_int);
    end
    step(2);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_beats_intr got stall=%b exp 0", stall); end
  endtask

  task automatic test_basic_entry();
    pc_current = 32'h0000_1234; ccr_current = 5'b00101;
    intr = 1'b1; step(); intr = 1'b0;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL entry_pending_stall got %b exp 0", stall); end
    step();
    tests++; if (stall !== 1'b1 || out !== 16'h2800 || push_data !== 16'h0000) begin
      fails++; $display("FAIL push_hi got stall=%b out=%h push=%h exp 1/2800/0000", stall, out, push_data);
    end
    pc_current = 32'hFFFF_FFFF; ccr_current = 5'b11111;
    step();
    tests++; if (stall !== 1'b1 || out !== 16'h2800 || push_data !== 16'h1234) begin
      fails++; $display("FAIL push_lo got stall=%b out=%h push=%h exp 1/2800/1234", stall, out, push_data);
    end
    step();
    tests++; if (stall !== 1'b1 || out !== 16'h2800 || push_data !== 16'h0005) begin
      fails++; $display("FAIL push_ccr got stall=%b out=%h push=%h exp 1/2800/0005", stall, out, push_data);
    end
    step();
    tests++; if (stall !== 1'b1 || change_pc_int !== 1'b1 || pc !== 32'h10 || out !== 16'h0000 || push_data !== 16'h0) begin
      fails++; $display("FAIL jump got stall=%b cpc=%b pc=%h out=%h push=%h exp 1/1/00000010/0000/0000", stall, change_pc_int, pc, out, push_data);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (stall !== 1'b1 || out !== 16'h0000 || change_pc_int !== 1'b0 || pc !== 32'h0 || in_isr !== 1'b1) begin
        fails++; $display("FAIL drain%0d got stall=%b out=%h cpc=%b pc=%h isr=%b exp 1/0000/0/0/1", i, stall, out, change_pc_int, pc, in_isr);
      end
    end
    step();
    tests++; if (stall !== 1'b0 || in_isr !== 1'b1) begin
      fails++; $display("FAIL after_drain got stall=%b isr=%b exp 0/1", stall, in_isr);
    end
    clear_isr();
    tests++; if (in_isr !== 1'b0) begin fails++; $display("FAIL rti_clear got %b exp 0", in_isr); end
  endtask

  task automatic test_busy_holdoff();
    pc_current = 32'hABCD_0000; ccr_current = 5'b10000;
    busy = 1'b1;
    intr = 1'b1; step(); intr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL busy_hold%0d got stall=%b exp 0", i, stall); end
    end
    busy = 1'b0;
    step();
    tests++; if (stall !== 1'b1 || push_data !== 16'hABCD) begin
      fails++; $display("FAIL busy_release got stall=%b push=%h exp 1/abcd", stall, push_data);
    end
    busy = 1'b1;
    step();
    tests++; if (stall !== 1'b1 || push_data !== 16'h0000 || out !== 16'h2800) begin
      fails++; $display("FAIL busy_ignored got stall=%b push=%h out=%h exp 1/0000/2800", stall, push_data, out);
    end
    step(2);
    tests++; if (change_pc_int !== 1'b1) begin fails++; $display("FAIL busy_jump got %b exp 1", change_pc_int); end
    busy = 1'b0;
    step(4);
    clear_isr();
  endtask

  task automatic test_nested_pending();
    pc_current = 32'h0000_0100; ccr_current = 5'b00001;
    intr = 1'b1; step(); intr = 1'b0;
    step(5);
    intr = 1'b1; step(); intr = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) begin
      tests++; if (stall !== 1'b0 || in_isr !== 1'b1) begin
        fails++; $display("FAIL nested_blocked%0d got stall=%b isr=%b exp 0/1", i, stall, in_isr);
      end
      step();
    end
    pc_current = 32'h0000_0200;
    rti = 1'b1; step(); rti = 1'b0;
    tests++; if (in_isr !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL nested_rti got isr=%b stall=%b exp 0/0", in_isr, stall);
    end
    step();
    tests++; if (stall !== 1'b1 || push_data !== 16'h0000) begin
      fails++; $display("FAIL nested_entry got stall=%b push=%h exp 1/0000", stall, push_data);
    end
    step();
    tests++; if (push_data !== 16'h0200) begin fails++; $display("FAIL nested_saved_pc got %h exp 0200", push_data); end
    step(6);
    clear_isr();
    step();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL merged_pulses got stall=%b exp 0", stall); end
  endtask

  task automatic test_reset_abort();
    pc_current = 32'h1111_2222; ccr_current = 5'b01010;
    intr = 1'b1; step(); intr = 1'b0;
    step(2);
    tests++; if (push_data !== 16'h2222 || stall !== 1'b1) begin
      fails++; $display("FAIL abort_push_lo got push=%h stall=%b exp 2222/1", push_data, stall);
    end
    reset = 1'b1; step(); reset = 1'b0;
    tests++; if (stall !== 1'b0 || in_isr !== 1'b0 || push_data !== 16'h0) begin
      fails++; $display("FAIL abort_idle got stall=%b isr=%b push=%h exp 0/0/0000", stall, in_isr, push_data);
    end
    step(2);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL abort_no_resume got %b exp 0", stall); end
    pc_current = 32'h3333_4444; ccr_current = 5'b00011;
    intr = 1'b1; step(); intr = 1'b0;
    step();
    tests++; if (push_data !== 16'h3333) begin fails++; $display("FAIL fresh_hi got %h exp 3333", push_data); end
    step();
    tests++; if (push_data !== 16'h4444) begin fails++; $display("FAIL fresh_lo got %h exp 4444", push_data); end
    step();
    tests++; if (push_data !== 16'h0003) begin fails++; $display("FAIL fresh_ccr got %h exp 0003", push_data); end
    step(5);
    tests++; if (in_isr !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL fresh_done got isr=%b stall=%b exp 1/0", in_isr, stall);
    end
    clear_isr();
  endtask

  task automatic test_rti_cases();
    rti = 1'b1; step(); rti = 1'b0;
    tests++; if (stall !== 1'b0 || in_isr !== 1'b0 || out !== 16'h0 || change_pc_int !== 1'b0) begin
      fails++; $display("FAIL rti_idle got stall=%b isr=%b out=%h cpc=%b exp 0/0/0000/0", stall, in_isr, out, change_pc_int);
    end
    run_entry();
    tests++; if (in_isr !== 1'b1) begin fails++; $display("FAIL rti_setup got %b exp 1", in_isr); end
    rti = 1'b1; intr = 1'b1; step(); rti = 1'b0; intr = 1'b0;
    tests++; if (in_isr !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL rti_intr_same got isr=%b stall=%b exp 0/0", in_isr, stall);
    end
    step();
    tests++; if (stall !== 1'b1 || out !== 16'h2800) begin
      fails++; $display("FAIL rti_intr_entry got stall=%b out=%h exp 1/2800", stall, out);
    end
    step(7);
    clear_isr();
  endtask

  initial begin
    reset = 1'b1; intr = 1'b0; busy = 1'b0; rti = 1'b0;
    pc_current = '0; ccr_current = '0;
    test_reset();
    test_basic_entry();
    test_busy_holdoff();
    test_nested_pending();
    test_reset_abort();
    test_rti_cases();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
